// File: rtl/gbuff_pkg.sv
// ----------------------------------------------------------------------------
// gbuff_pkg
// Shared definitions for the global-buffer stream reader:
//   - default ADDR_BITS / DATA_BITS for the reader and its stream interface
//   - depth of the output FIFO and the width of its occupancy count
//   - the reader state encoding
// No ports (package).
// ----------------------------------------------------------------------------
package gbuff_pkg;

    localparam int DEF_ADDR_BITS = 8;
    localparam int DEF_DATA_BITS = 32;

    // Two entries are enough to sustain one word per cycle with a registered
    // read enable: one entry being presented, one being filled.
    localparam int FIFO_DEPTH    = 2;
    localparam int FIFO_CNT_BITS = $clog2(FIFO_DEPTH + 1);

    // IDLE  : waiting for start
    // RUN   : reads still to be issued
    // DRAIN : all reads issued, FIFO still holds words
    // FIN   : one-cycle done pulse
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } rdState_t;

endpackage

// File: rtl/gbuff_stream_reader_if.sv
// ----------------------------------------------------------------------------
// gbuff_stream_reader_if
// Valid/ready word stream produced by gbuff_stream_reader.
//   m_valid : word valid (producer -> consumer)
//   m_ready : consumer ready (consumer -> producer)
//   m_data  : word (DATA_BITS)
//   m_last  : final word of a burst, qualified by m_valid
// Modports: master (producer side), slave (consumer side).
// ----------------------------------------------------------------------------
interface gbuff_stream_reader_if
    import gbuff_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
);

    logic                 m_valid;
    logic                 m_ready;
    logic [DATA_BITS-1:0] m_data;
    logic                 m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);

endinterface

// File: rtl/gbuff_rd_fifo.sv
// ----------------------------------------------------------------------------
// gbuff_rd_fifo
// Two-entry FIFO holding read words plus their "last" flag.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (clears contents)
//   flush_i       : empties the FIFO (pointers and count only)
//   push_i        : write pushData_i / pushLast_i at this cycle's end
//   pop_i         : consumer took the head word this cycle
//   valid_o       : FIFO non-empty
//   data_o/last_o : head word and its last flag (last_o qualified by valid_o)
//   count_o       : registered occupancy 0..2
// ----------------------------------------------------------------------------
module gbuff_rd_fifo
    import gbuff_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [DATA_BITS-1:0]     pushData_i,
    input  logic                     pushLast_i,
    input  logic                     pop_i,
    output logic                     valid_o,
    output logic [DATA_BITS-1:0]     data_o,
    output logic                     last_o,
    output logic [FIFO_CNT_BITS-1:0] count_o
);

    logic [DATA_BITS-1:0]     data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]    last_q;
    logic                     wrPtr_q;
    logic                     rdPtr_q;
    logic [FIFO_CNT_BITS-1:0] count_q;
    logic                     pushOk;
    logic                     popOk;

    // A push into a full FIFO is only accepted when the head leaves in the
    // same cycle; the reader never relies on this, it is a safety net.
    assign popOk  = pop_i && (count_q != '0);
    assign pushOk = push_i && ((count_q != FIFO_CNT_BITS'(FIFO_DEPTH)) || popOk);

    // Storage and pointers. With two entries the pointers are single bits
    // that simply toggle. Flush keeps stale data but makes it invisible.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i] <= '0;
            end
            last_q  <= '0;
            wrPtr_q <= 1'b0;
            rdPtr_q <= 1'b0;
            count_q <= '0;
        end else if (flush_i) begin
            wrPtr_q <= 1'b0;
            rdPtr_q <= 1'b0;
            count_q <= '0;
        end else begin
            if (pushOk) begin
                data_q[wrPtr_q] <= pushData_i;
                last_q[wrPtr_q] <= pushLast_i;
                wrPtr_q         <= ~wrPtr_q;
            end
            if (popOk) begin
                rdPtr_q <= ~rdPtr_q;
            end
            count_q <= count_q + FIFO_CNT_BITS'(pushOk) - FIFO_CNT_BITS'(popOk);
        end
    end

    assign valid_o = (count_q != '0);
    assign data_o  = data_q[rdPtr_q];
    assign last_o  = valid_o && last_q[rdPtr_q];
    assign count_o = count_q;

endmodule

// File: rtl/gbuff_stream_reader.sv
// ----------------------------------------------------------------------------
// gbuff_stream_reader
// Reads a burst of words from a global buffer and streams them out over a
// valid/ready interface through a 2-entry FIFO.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : begin a burst (sampled only in IDLE)
//   abort        : cancel the current burst (priority over start)
//   base_addr    : first word index
//   length       : word count 0..2**ADDR_BITS
//   stride       : index step, only with GBUFF_RD_STRIDE_EN defined
//   busy, done   : status; done pulses one cycle after the last word leaves
//   ram_en/wr_en : buffer enable (registered) / write enable (always 0)
//   index        : buffer word address (registered)
//   ram_data     : buffer read data, valid at the end of the ram_en cycle
//   strm         : stream master (m_valid/m_ready/m_data/m_last)
// Configuration macro: GBUFF_RD_STRIDE_EN adds the stride port; without it
// the index step is fixed at 1.
// ----------------------------------------------------------------------------
module gbuff_stream_reader
    import gbuff_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int DATA_BITS = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [ADDR_BITS:0]   length,
`ifdef GBUFF_RD_STRIDE_EN
    input  logic [ADDR_BITS-1:0] stride,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 ram_en,
    output logic                 wr_en,
    output logic [ADDR_BITS-1:0] index,
    input  logic [DATA_BITS-1:0] ram_data,
    gbuff_stream_reader_if.master strm
);

    rdState_t                 state_q, state_d;
    logic [ADDR_BITS:0]       remaining_q, remaining_d;
    logic [ADDR_BITS-1:0]     index_q, index_d;
    logic                     ramEn_q, ramEn_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [ADDR_BITS-1:0]     step;
    logic [ADDR_BITS:0]       remNext;
    logic [FIFO_CNT_BITS:0]   countNext;
    logic                     fifoValid;
    logic                     fifoLast;
    logic [DATA_BITS-1:0]     fifoData;
    logic [FIFO_CNT_BITS-1:0] fifoCount;
    logic                     pop;

`ifdef GBUFF_RD_STRIDE_EN
    logic [ADDR_BITS-1:0]     stride_q, stride_d;
    assign step = stride_q;
`else
    assign step = ADDR_BITS'(1);
`endif

    assign pop = fifoValid && strm.m_ready;

    // Every issued read lands in the FIFO at the end of its cycle, since the
    // buffer presents the word by the falling edge of the ram_en cycle.
    gbuff_rd_fifo #(
        .DATA_BITS (DATA_BITS)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (abort),
        .push_i     (ramEn_q),
        .pushData_i (ram_data),
        .pushLast_i (remaining_q == (ADDR_BITS+1)'(1)),
        .pop_i      (pop),
        .valid_o    (fifoValid),
        .data_o     (fifoData),
        .last_o     (fifoLast),
        .count_o    (fifoCount)
    );

    // Next-state logic. The read enable for the next cycle is decided from
    // the occupancy that will exist then (this cycle's push and pop applied),
    // so a read is only ever issued into a FIFO holding at most one word.
    // m_ready therefore reaches ram_en only through a flop.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        index_d     = index_q;
        ramEn_d     = 1'b0;
`ifdef GBUFF_RD_STRIDE_EN
        stride_d    = stride_q;
`endif
        countNext = {1'b0, fifoCount} + (FIFO_CNT_BITS+1)'(ramEn_q)
                    - (FIFO_CNT_BITS+1)'(pop);
        remNext   = ramEn_q ? (remaining_q - (ADDR_BITS+1)'(1)) : remaining_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d     = ST_RUN;
                        remaining_d = length;
                        index_d     = base_addr;
                        ramEn_d     = 1'b1;
`ifdef GBUFF_RD_STRIDE_EN
                        stride_d    = stride;
`endif
                    end
                end
            end
            ST_RUN: begin
                remaining_d = remNext;
                if (ramEn_q) begin
                    index_d = index_q + step;
                end
                if (remNext == '0) begin
                    state_d = ST_DRAIN;
                end else begin
                    ramEn_d = (countNext < (FIFO_CNT_BITS+1)'(FIFO_DEPTH));
                end
            end
            ST_DRAIN: begin
                if (pop && fifoLast) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d = ST_IDLE;
            ramEn_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FIN);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            index_q     <= '0;
            ramEn_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef GBUFF_RD_STRIDE_EN
            stride_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            index_q     <= index_d;
            ramEn_q     <= ramEn_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef GBUFF_RD_STRIDE_EN
            stride_q    <= stride_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign ram_en      = ramEn_q;
    assign wr_en       = 1'b0;
    assign index       = index_q;
    assign strm.m_valid = fifoValid;
    assign strm.m_data  = fifoData;
    assign strm.m_last  = fifoLast;

endmodule

// File: tb/tb_gbuff_stream_reader.sv
// ----------------------------------------------------------------------------
// tb_gbuff_stream_reader
// Self-checking bench for gbuff_stream_reader. A behavioural buffer model
// answers reads on the falling edge; expected streams are computed directly
// from base/length/stride arithmetic over the buffer contents.
// Honors GBUFF_RD_STRIDE_EN when defined.
// ----------------------------------------------------------------------------
module tb_gbuff_stream_reader;
    import gbuff_pkg::*;

    localparam int AB    = 8;
    localparam int DB    = 32;
    localparam int DEPTH = 1 << AB;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AB-1:0] base_addr = '0;
    logic [AB:0]   length = '0;
    logic [AB-1:0] stride = 8'd1;
    logic          busy, done, ram_en, wr_en;
    logic [AB-1:0] index;
    logic [DB-1:0] ram_data = '0;

    gbuff_stream_reader_if #(.DATA_BITS(DB)) sif();

    gbuff_stream_reader #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .length    (length),
`ifdef GBUFF_RD_STRIDE_EN
        .stride    (stride),
`endif
        .busy      (busy),
        .done      (done),
        .ram_en    (ram_en),
        .wr_en     (wr_en),
        .index     (index),
        .ram_data  (ram_data),
        .strm      (sif)
    );

    always #5 clk = ~clk;

    // Buffer model: read data appears on the falling edge of an enabled cycle
    // and holds otherwise.
    logic [DB-1:0] gmem [DEPTH];
    always @(negedge clk) begin
        if (ram_en && !wr_en) ram_data = gmem[index];
    end

    int compared = 0;
    int mismatched = 0;

    // Observation state, refreshed every cycle by step().
    int            cyc = 0;
    int            startCyc, firstValidCyc, doneCyc;
    int            doneCount, ramEnCount, validCount;
    int            occ = 0;
    int            occViol, stallViol;
    bit            prevStall;
    logic [DB-1:0] prevData;
    logic [AB-1:0] idxQ[$];
    logic [DB-1:0] obsData[$];
    bit            obsLast[$];
    int            hsCyc[$];

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int effStride(int s);
`ifdef GBUFF_RD_STRIDE_EN
        return s;
`else
        return 1;
`endif
    endfunction

    function automatic logic [DB-1:0] modelWord(int b, int s, int i);
        return gmem[(b + i * effStride(s)) % DEPTH];
    endfunction

    function automatic logic [AB-1:0] modelIdx(int b, int s, int i);
        return AB'((b + i * effStride(s)) % DEPTH);
    endfunction

    // One clock: sample at the falling edge, return 1 time unit after the
    // following rising edge so inputs change away from the active edge.
    task automatic step();
        bit hs;
        @(negedge clk);
        hs = sif.m_valid && sif.m_ready;
        if (ram_en) begin
            idxQ.push_back(index);
            ramEnCount++;
            if (occ >= FIFO_DEPTH) occViol++;
        end
        if (hs) begin
            obsData.push_back(sif.m_data);
            obsLast.push_back(sif.m_last);
            hsCyc.push_back(cyc);
        end
        if (sif.m_valid) begin
            validCount++;
            if (firstValidCyc < 0) firstValidCyc = cyc;
        end
        if (prevStall && (!sif.m_valid || sif.m_data != prevData)) stallViol++;
        if (done) begin
            doneCount++;
            doneCyc = cyc;
        end
        if (abort || rst) begin
            occ = 0;
            prevStall = 0;
        end else begin
            occ = occ + int'(ram_en) - int'(hs);
            prevStall = sif.m_valid && !sif.m_ready;
        end
        prevData = sif.m_data;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        idxQ.delete(); obsData.delete(); obsLast.delete(); hsCyc.delete();
        firstValidCyc = -1; doneCyc = -1; doneCount = 0; ramEnCount = 0;
        validCount = 0; occViol = 0; stallViol = 0; prevStall = 0;
    endtask

    // mode 0: always ready, 1: ready 1,0,0 repeating, 2: random ready plus
    // spurious start pulses while busy.
    task automatic run_burst(input int b, input int len, input int s,
                             input int mode, input int maxCyc, output bit timedOut);
        clear_obs();
        base_addr = AB'(b); length = (AB+1)'(len); stride = AB'(s);
        sif.m_ready = (mode == 0);
        start = 1'b1; startCyc = cyc;
        step();
        start = 1'b0;
        for (int k = 0; k < maxCyc && doneCount == 0; k++) begin
            case (mode)
                0: sif.m_ready = 1'b1;
                1: sif.m_ready = (k % 3 == 0);
                default: begin
                    sif.m_ready = 1'($urandom_range(0, 1));
                    start     = ($urandom_range(0, 3) == 0);
                    base_addr = AB'($urandom);
                    length    = (AB+1)'($urandom);
                    stride    = AB'($urandom);
                end
            endcase
            step();
        end
        start = 1'b0;
        timedOut = (doneCount == 0);
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        compared++; if (ram_en !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ram_en: got %b want 0", ram_en); end
        compared++; if (wr_en !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_wr_en: got %b want 0", wr_en); end
        compared++; if (index !== '0) begin mismatched++; $display("[TB] FAIL reset_index: got %h want 0", index); end
        compared++; if (sif.m_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_m_valid: got %b want 0", sif.m_valid); end
        compared++; if (sif.m_last !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_m_last: got %b want 0", sif.m_last); end
        compared++; if (sif.m_data !== '0) begin mismatched++; $display("[TB] FAIL reset_m_data: got %h want 0", sif.m_data); end
    endtask

    task automatic test_basic();
        bit to;
        run_burst('h10, 4, 1, 0, 40, to);
        compared++; if (to !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_timeout: no done seen"); end
        compared++; if (obsData.size() !== 4) begin mismatched++; $display("[TB] FAIL basic_count: got %0d want 4", obsData.size()); end
        for (int i = 0; i < 4 && i < obsData.size(); i++) begin
            compared++; if (obsData[i] !== modelWord('h10, 1, i)) begin mismatched++; $display("[TB] FAIL basic_data[%0d]: got %h want %h", i, obsData[i], modelWord('h10, 1, i)); end
            compared++; if (obsLast[i] !== (i == 3)) begin mismatched++; $display("[TB] FAIL basic_last[%0d]: got %b want %b", i, obsLast[i], (i == 3)); end
            compared++; if (hsCyc[i] !== startCyc + 2 + i) begin mismatched++; $display("[TB] FAIL basic_timing[%0d]: got cycle %0d want %0d", i, hsCyc[i], startCyc + 2 + i); end
        end
        compared++; if (doneCount !== 1) begin mismatched++; $display("[TB] FAIL basic_done_count: got %0d want 1", doneCount); end
        compared++; if (doneCyc !== startCyc + 6) begin mismatched++; $display("[TB] FAIL basic_done_cycle: got %0d want %0d", doneCyc, startCyc + 6); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_wrap();
        bit to;
        run_burst('hFE, 4, 1, 0, 40, to);
        compared++; if (to !== 1'b0) begin mismatched++; $display("[TB] FAIL wrap_timeout: no done seen"); end
        compared++; if (idxQ.size() !== 4) begin mismatched++; $display("[TB] FAIL wrap_reads: got %0d want 4", idxQ.size()); end
        for (int i = 0; i < 4 && i < idxQ.size(); i++) begin
            compared++; if (idxQ[i] !== modelIdx('hFE, 1, i)) begin mismatched++; $display("[TB] FAIL wrap_index[%0d]: got %h want %h", i, idxQ[i], modelIdx('hFE, 1, i)); end
        end
        for (int i = 0; i < 4 && i < obsData.size(); i++) begin
            compared++; if (obsData[i] !== modelWord('hFE, 1, i)) begin mismatched++; $display("[TB] FAIL wrap_data[%0d]: got %h want %h", i, obsData[i], modelWord('hFE, 1, i)); end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        int b = $urandom_range(0, DEPTH - 1);
        run_burst(b, 8, 1, 1, 100, to);
        compared++; if (to !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_timeout: no done seen"); end
        compared++; if (obsData.size() !== 8) begin mismatched++; $display("[TB] FAIL bp_count: got %0d want 8", obsData.size()); end
        for (int i = 0; i < 8 && i < obsData.size(); i++) begin
            compared++; if (obsData[i] !== modelWord(b, 1, i) || obsLast[i] !== (i == 7)) begin mismatched++; $display("[TB] FAIL bp_word[%0d]: got %h/%b want %h/%b", i, obsData[i], obsLast[i], modelWord(b, 1, i), (i == 7)); end
        end
        compared++; if (occViol !== 0) begin mismatched++; $display("[TB] FAIL bp_read_into_full: got %0d want 0", occViol); end
        compared++; if (stallViol !== 0) begin mismatched++; $display("[TB] FAIL bp_stall_stable: got %0d want 0", stallViol); end
        compared++; if (doneCount !== 1) begin mismatched++; $display("[TB] FAIL bp_done_count: got %0d want 1", doneCount); end
    endtask

    task automatic test_zero_length();
        bit to;
        run_burst($urandom_range(0, DEPTH - 1), 0, 1, 0, 6, to);
        compared++; if (to !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_timeout: no done seen"); end
        compared++; if ((doneCyc - startCyc <= 2) !== 1'b1) begin mismatched++; $display("[TB] FAIL zero_done_latency: got %0d want <=2", doneCyc - startCyc); end
        compared++; if (ramEnCount !== 0) begin mismatched++; $display("[TB] FAIL zero_ram_en: got %0d want 0", ramEnCount); end
        compared++; if (validCount !== 0) begin mismatched++; $display("[TB] FAIL zero_m_valid: got %0d want 0", validCount); end
        compared++; if (doneCount !== 1) begin mismatched++; $display("[TB] FAIL zero_done_count: got %0d want 1", doneCount); end
    endtask

    task automatic test_abort();
        bit to;
        int b = $urandom_range(0, DEPTH - 1);
        int enBefore;
        clear_obs();
        base_addr = AB'(b); length = 9'd10; stride = 8'd1;
        sif.m_ready = 1'b1;
        start = 1'b1; startCyc = cyc;
        step();
        start = 1'b0;
        for (int k = 0; k < 40 && obsData.size() < 3; k++) step();
        compared++; if (obsData.size() < 3) begin mismatched++; $display("[TB] FAIL abort_wait: got %0d words want 3", obsData.size()); end
        for (int i = 0; i < 3 && i < obsData.size(); i++) begin
            compared++; if (obsData[i] !== modelWord(b, 1, i)) begin mismatched++; $display("[TB] FAIL abort_data[%0d]: got %h want %h", i, obsData[i], modelWord(b, 1, i)); end
        end
        abort = 1'b1; start = 1'b1;
        step();
        abort = 1'b0; start = 1'b0;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_busy: got %b want 0", busy); end
        compared++; if (sif.m_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_m_valid: got %b want 0", sif.m_valid); end
        compared++; if (ram_en !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_ram_en: got %b want 0", ram_en); end
        enBefore = ramEnCount;
        step(); step(); step();
        compared++; if (doneCount !== 0) begin mismatched++; $display("[TB] FAIL abort_no_done: got %0d want 0", doneCount); end
        compared++; if (ramEnCount !== enBefore) begin mismatched++; $display("[TB] FAIL abort_no_reads: got %0d want %0d", ramEnCount, enBefore); end
        run_burst('h40, 2, 1, 0, 40, to);
        compared++; if (to !== 1'b0 || obsData.size() !== 2) begin mismatched++; $display("[TB] FAIL abort_restart: timeout %b words %0d want 0/2", to, obsData.size()); end
        for (int i = 0; i < 2 && i < obsData.size(); i++) begin
            compared++; if (obsData[i] !== modelWord('h40, 1, i) || obsLast[i] !== (i == 1)) begin mismatched++; $display("[TB] FAIL abort_restart_word[%0d]: got %h/%b want %h/%b", i, obsData[i], obsLast[i], modelWord('h40, 1, i), (i == 1)); end
        end
    endtask

    task automatic test_random();
        bit to;
        for (int n = 0; n < 8; n++) begin
            int b   = $urandom_range(0, DEPTH - 1);
            int s   = $urandom_range(0, 7);
            int len = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 24);
            run_burst(b, len, s, 2, 400, to);
            compared++; if (to !== 1'b0 || obsData.size() !== len) begin mismatched++; $display("[TB] FAIL rand%0d_count: timeout %b words %0d want %0d", n, to, obsData.size(), len); end
            for (int i = 0; i < len && i < obsData.size(); i++) begin
                compared++; if (obsData[i] !== modelWord(b, s, i) || obsLast[i] !== (i == len - 1)) begin mismatched++; $display("[TB] FAIL rand%0d_word[%0d]: got %h/%b want %h/%b", n, i, obsData[i], obsLast[i], modelWord(b, s, i), (i == len - 1)); end
            end
            compared++; if (doneCount !== 1 || occViol !== 0 || stallViol !== 0) begin mismatched++; $display("[TB] FAIL rand%0d_protocol: done %0d full-reads %0d stall-changes %0d want 1/0/0", n, doneCount, occViol, stallViol); end
        end
    endtask

    task automatic test_full_depth();
        bit to;
        int seen [DEPTH];
        int b = $urandom_range(0, DEPTH - 1);
        int badIdx = 0;
        int badWord = 0;
        run_burst(b, DEPTH, 1, 2, 3000, to);
        for (int i = 0; i < DEPTH; i++) seen[i] = 0;
        foreach (idxQ[i]) seen[idxQ[i]]++;
        for (int i = 0; i < DEPTH; i++) if (seen[i] != 1) badIdx++;
        for (int i = 0; i < obsData.size() && i < DEPTH; i++) if (obsData[i] !== modelWord(b, 1, i)) badWord++;
        compared++; if (to !== 1'b0 || obsData.size() !== DEPTH) begin mismatched++; $display("[TB] FAIL full_count: timeout %b words %0d want 0/%0d", to, obsData.size(), DEPTH); end
        compared++; if (badIdx !== 0) begin mismatched++; $display("[TB] FAIL full_each_once: got %0d bad indices want 0", badIdx); end
        compared++; if (badWord !== 0) begin mismatched++; $display("[TB] FAIL full_data: got %0d bad words want 0", badWord); end
    endtask

`ifdef GBUFF_RD_STRIDE_EN
    task automatic test_stride();
        bit to;
        run_burst(0, 3, 4, 0, 40, to);
        compared++; if (to !== 1'b0 || idxQ.size() !== 3) begin mismatched++; $display("[TB] FAIL stride_reads: timeout %b reads %0d want 0/3", to, idxQ.size()); end
        for (int i = 0; i < 3 && i < idxQ.size(); i++) begin
            compared++; if (idxQ[i] !== AB'(4 * i)) begin mismatched++; $display("[TB] FAIL stride_index[%0d]: got %h want %h", i, idxQ[i], AB'(4 * i)); end
        end
        run_burst('h21, 3, 0, 0, 40, to);
        for (int i = 0; i < 3 && i < idxQ.size(); i++) begin
            compared++; if (idxQ[i] !== AB'('h21) || obsData[i] !== gmem['h21]) begin mismatched++; $display("[TB] FAIL stride0_word[%0d]: got %h/%h want 21/%h", i, idxQ[i], obsData[i], gmem['h21]); end
        end
    endtask
`endif

    task automatic test_reset_mid();
        clear_obs();
        base_addr = AB'($urandom); length = 9'd20; stride = 8'd3;
        start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sif.m_ready = 1'($urandom_range(0, 1));
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        compared++; if (busy !== 1'b0 || done !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_status: busy %b done %b want 0/0", busy, done); end
        compared++; if (ram_en !== 1'b0 || index !== '0) begin mismatched++; $display("[TB] FAIL midrst_ram: ram_en %b index %h want 0/00", ram_en, index); end
        compared++; if (sif.m_valid !== 1'b0 || sif.m_last !== 1'b0 || sif.m_data !== '0) begin mismatched++; $display("[TB] FAIL midrst_stream: valid %b last %b data %h want 0/0/0", sif.m_valid, sif.m_last, sif.m_data); end
        clear_obs();
        for (int k = 0; k < 6; k++) step();
        compared++; if (ramEnCount !== 0 || doneCount !== 0 || validCount !== 0) begin mismatched++; $display("[TB] FAIL midrst_quiet: reads %0d done %0d valid %0d want 0/0/0", ramEnCount, doneCount, validCount); end
    endtask

    initial begin
        sif.m_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) gmem[i] = DB'(i * 3);
        clear_obs();
        rst = 1'b1;
        test_reset();
        test_basic();
        for (int i = 0; i < DEPTH; i++) gmem[i] = $urandom;
        test_wrap();
        test_backpressure();
        test_zero_length();
        test_abort();
        test_random();
        test_full_depth();
`ifdef GBUFF_RD_STRIDE_EN
        test_stride();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/gbuff_stream_reader.md
GBUFF_STREAM_READER -- requirements
Module: gbuff_stream_reader

Interface
REQ-001 Parameter ADDR_BITS, default 8, global-buffer index width; DEPTH = 2**ADDR_BITS.
REQ-002 Parameter DATA_BITS, default 32, word width.
REQ-003 clk  input  1  sole clock; all block flops update on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 abort  input  1  cancels the current burst.
REQ-007 base_addr  input  ADDR_BITS  first word index of burst.
REQ-008 length  input  ADDR_BITS+1  word count, 0..DEPTH.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 done  output  1  one-cycle pulse after the last word is accepted downstream.
REQ-011 ram_en  output  1  buffer enable, driven from a flop.
REQ-012 wr_en  output  1  buffer write enable, constant 0.
REQ-013 index  output  ADDR_BITS  buffer word address, driven from a flop.
REQ-014 ram_data  input  DATA_BITS  buffer read-data port.
REQ-015 m_valid  output  1  stream word valid.
REQ-016 m_ready  input  1  stream consumer ready.
REQ-017 m_data  output  DATA_BITS  stream word.
REQ-018 m_last  output  1  marks final word of burst, qualified by m_valid.

Function
REQ-019 Buffer timing: read-data updates on the falling edge of the cycle in which ram_en=1 and wr_en=0, then holds while ram_en=0; the block SHALL capture ram_data at the rising edge ending that cycle (one-cycle read, no extra in-flight tracking).
REQ-020 States: IDLE, RUN (reads outstanding), DRAIN (all reads issued, FIFO non-empty), FIN (done pulse); encoding lives in the package.
REQ-021 IDLE + start, length>0: latch base_addr/length, go RUN; IDLE + start, length=0: go FIN directly, no reads issued.
REQ-022 start while busy SHALL be ignored.
REQ-023 Output path is a 2-entry FIFO feeding m_data/m_valid/m_last; m_data stable while m_valid && !m_ready.
REQ-024 In RUN, ram_en=1 in a cycle iff remaining>0 and registered FIFO count<2 after accounting for this cycle's push; ram_en SHALL NOT depend combinationally on m_ready.
REQ-025 Each issued read pushes one FIFO entry at cycle end; m_last set on the entry for the final read.
REQ-026 index increments by the stride per issued read, modulo DEPTH (wrap 2**ADDR_BITS-1 -> 0 without error).
REQ-027 Sustained m_ready=1 SHALL give one word per cycle after the first, first m_valid two cycles after start.
REQ-028 RUN -> DRAIN when remaining reaches 0; DRAIN -> FIN when the m_last word handshakes; FIN -> IDLE next cycle with done=1 for exactly that cycle.
REQ-029 abort in any state: next cycle IDLE, FIFO flushed, m_valid=0, ram_en=0, done not pulsed; abort has priority over start.
REQ-030 length=DEPTH reads every word exactly once.

Reset
REQ-031 rst SHALL yield: state IDLE, busy=0, done=0, ram_en=0, wr_en=0, index=0, m_valid=0, m_last=0, m_data=0, FIFO empty.
REQ-032 rst mid-burst SHALL discard the burst with no done pulse and no further ram_en.

Configuration
REQ-033 Macro GBUFF_RD_STRIDE_EN defined: extra input stride (ADDR_BITS wide, latched on start; 0 rereads base_addr length times).
REQ-034 Macro undefined: no stride port, stride fixed at 1.

Structure
REQ-035 Shared package gbuff_pkg holds the state enum, FIFO depth constant (2) and default ADDR_BITS/DATA_BITS.
REQ-036 One sub-module gbuff_rd_fifo (2-entry, data+last, count output); remainder in the top.

Verification
REQ-037 base=0x10, length=4, m_ready=1, buffer[i]=i*3 -> m_data 0x30,0x33,0x36,0x39 consecutive cycles, m_last on 0x39, done one cycle later.
REQ-038 base=0xFE, length=4 -> index 0xFE,0xFF,0x00,0x01; data matches those entries.
REQ-039 length=8, m_ready toggling 1,0,0,1... -> no word lost or duplicated, ram_en never issued with FIFO count=2, m_data stable while stalled.
REQ-040 length=0 start -> done pulse within 2 cycles, ram_en never asserted, m_valid stays 0.
REQ-041 abort after 3 of 10 words accepted -> IDLE next cycle, m_valid=0, no done; new start base=0x40 length=2 then completes normally.
REQ-042 With GBUFF_RD_STRIDE_EN, base=0, stride=4, length=3 -> index 0,4,8; rst asserted mid-burst -> all outputs at reset values next cycle.
